// File: rtl/reg_list_sequencer.sv
// Multi-register transfer engine (LDM/STM style).
// Walks a 16-bit register list in ascending order and issues one memory beat
// per listed register. It then optionally writes the updated base register back.
module reg_list_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              up,
    input  logic              pre,
    input  logic              writeback,
    input  logic [3:0]        base_reg,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       reg_list,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] r_data_a,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        r_addr_a,
    output logic [3:0]        w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              write_reg,
    output logic              write_pc,
    output logic [DATA_W-1:0] pc_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_WB,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic              is_load_q;
    logic              up_q;
    logic              pre_q;
    logic              wb_q;
    logic              wb_en_q;
    logic [3:0]        base_reg_q;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       list_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] final_q;

    logic [4:0]        cnt;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] final_addr;
    logic [3:0]        cur_reg;
    logic [15:0]       list_next;

    // Count the listed registers and derive first-beat and final base addresses
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(list_q[i]);
        end
        span = ADDR_W'({cnt, 2'b00});
        if (up_q) begin
            start_addr = pre_q ? (base_q + ADDR_W'(4)) : base_q;
            final_addr = base_q + span;
        end else begin
            start_addr = pre_q ? (base_q - span) : (base_q - span + ADDR_W'(4));
            final_addr = base_q - span;
        end
    end

    // Pick the lowest remaining register and the list left after serving it
    always_comb begin
        cur_reg = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) begin
                cur_reg = 4'(i);
            end
        end
        list_next = list_q & ~(16'b1 << cur_reg);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the request, then track the remaining list and the beat address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_load_q  <= 1'b0;
            up_q       <= 1'b0;
            pre_q      <= 1'b0;
            wb_q       <= 1'b0;
            wb_en_q    <= 1'b0;
            base_reg_q <= '0;
            base_q     <= '0;
            list_q     <= '0;
            addr_q     <= '0;
            final_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_load_q  <= is_load;
                        up_q       <= up;
                        pre_q      <= pre;
                        wb_q       <= writeback;
                        wb_en_q    <= writeback && !(is_load && reg_list[base_reg])
                                      && (base_reg != 4'hF);
                        base_reg_q <= base_reg;
                        base_q     <= base_addr;
                        list_q     <= reg_list;
                    end
                end
                S_SETUP: begin
                    addr_q  <= start_addr;
                    final_q <= final_addr;
                end
                S_XFER: begin
                    if (mem_ready) begin
                        list_q <= list_next;
                        addr_q <= addr_q + ADDR_W'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode; every strobe is low unless its state drives it
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        r_addr_a   = '0;
        w_addr     = '0;
        w_data     = '0;
        write_reg  = 1'b0;
        write_pc   = 1'b0;
        pc_data    = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                busy       = 1'b1;
                next_state = (cnt == 5'd0) ? S_DONE : S_XFER;
            end
            S_XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = !is_load_q;
                mem_addr = addr_q;
                if (!is_load_q) begin
                    r_addr_a  = cur_reg;
                    mem_wdata = r_data_a;
                end else if (mem_ready) begin
                    if (cur_reg == 4'hF) begin
                        write_pc = 1'b1;
                        pc_data  = mem_rdata;
                    end else begin
                        write_reg = 1'b1;
                        w_addr    = cur_reg;
                        w_data    = mem_rdata;
                    end
                end
                if (mem_ready && (list_next == 16'h0000)) begin
                    next_state = wb_q ? S_WB : S_DONE;
                end
            end
            S_WB: begin
                busy       = 1'b1;
                write_reg  = wb_en_q;
                w_addr     = base_reg_q;
                w_data     = DATA_W'(final_q);
                next_state = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Scoreboard bench for reg_list_sequencer: expected beats and register writes
// are queued when a request is issued and retired as the sequencer produces them.
module tb_reg_list_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        up = 1'b0;
    logic        pre = 1'b0;
    logic        writeback = 1'b0;
    logic [3:0]  base_reg = '0;
    logic [31:0] base_addr = '0;
    logic [15:0] reg_list = '0;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_rdata;
    logic [31:0] r_data_a;
    logic        busy, done, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, w_data, pc_data;
    logic [3:0]  r_addr_a, w_addr;
    logic        write_reg, write_pc;

    localparam logic [31:0] LOAD_KEY = 32'h5A5A_F00D;

    reg_list_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .up(up),
        .pre(pre), .writeback(writeback), .base_reg(base_reg),
        .base_addr(base_addr), .reg_list(reg_list), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .r_data_a(r_data_a), .busy(busy), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .r_addr_a(r_addr_a), .w_addr(w_addr),
        .w_data(w_data), .write_reg(write_reg), .write_pc(write_pc),
        .pc_data(pc_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_value(input logic [3:0] rn);
        return 32'hC0DE_0000 + 32'(rn) * 32'h0000_0111;
    endfunction

    // Register file read port and memory return data
    assign r_data_a  = reg_value(r_addr_a);
    assign mem_rdata = mem_addr ^ LOAD_KEY;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  rn;
    } beat_t;

    typedef struct {
        logic        is_pc;
        logic [3:0]  rn;
        logic [31:0] data;
    } wr_t;

    beat_t exp_beats[$];
    wr_t   exp_writes[$];

    int checks_total = 0;
    int checks_passed = 0;
    bit mon_en = 1'b0;
    int beat_num = 0;
    int stall_at = -1;
    int stall_left = 0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Retire beats and register writes against the scoreboard
    always @(negedge clk) begin
        beat_t b;
        wr_t   w;
        if (rst && mon_en) begin
            if (prev_stall && mem_req) begin
                checkOutput("stall_addr", mem_addr, prev_addr);
                if (!mem_we) checkOutput("stall_wdata", mem_wdata, prev_wdata);
            end
            prev_stall = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            if (mem_req && mem_ready) begin
                if (exp_beats.size() == 0) begin
                    checkOutput("beat_expected", 32'(mem_req), 32'd0);
                end else begin
                    b = exp_beats.pop_front();
                    checkOutput("beat_addr", mem_addr, b.addr);
                    checkOutput("beat_we", 32'(mem_we), 32'(b.we));
                    if (b.we) begin
                        checkOutput("store_reg", 32'(r_addr_a), 32'(b.rn));
                        checkOutput("store_data", mem_wdata, reg_value(b.rn));
                    end
                end
                beat_num++;
            end
            if (write_reg || write_pc) begin
                checkOutput("wr_pc_excl", 32'(write_reg & write_pc), 32'd0);
                if (exp_writes.size() == 0) begin
                    checkOutput("write_expected", 32'({write_pc, write_reg}), 32'd0);
                end else begin
                    w = exp_writes.pop_front();
                    checkOutput("write_kind", 32'({write_pc, write_reg}),
                                w.is_pc ? 32'd2 : 32'd1);
                    if (w.is_pc) begin
                        checkOutput("pc_data", pc_data, w.data);
                    end else begin
                        checkOutput("w_addr", 32'(w_addr), 32'(w.rn));
                        checkOutput("w_data", w_data, w.data);
                    end
                end
            end
        end
    end

    // Memory handshake: optionally hold mem_ready low on a chosen beat
    always @(posedge clk) begin
        #1;
        if (mem_req && (beat_num == stall_at) && (stall_left > 0)) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = 1'b1;
        end
    end

    task automatic build_expect(input logic ld, input logic u, input logic p,
                                input logic wbk, input logic [3:0] br,
                                input logic [31:0] base, input logic [15:0] list);
        int          cnt;
        logic [31:0] span, addr, fin;
        cnt  = $countones(list);
        span = 32'(cnt) * 32'd4;
        if (u) begin
            addr = p ? base + 32'd4 : base;
            fin  = base + span;
        end else begin
            addr = p ? base - span : base - span + 32'd4;
            fin  = base - span;
        end
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                exp_beats.push_back('{we: !ld, addr: addr, rn: 4'(i)});
                if (ld) exp_writes.push_back('{is_pc: (i == 15), rn: 4'(i), data: addr ^ LOAD_KEY});
                addr = addr + 32'd4;
            end
        end
        if ((cnt != 0) && wbk && !(ld && list[br]) && (br != 4'hF)) begin
            exp_writes.push_back('{is_pc: 1'b0, rn: br, data: fin});
        end
    endtask

    task automatic drive_request(input logic ld, input logic u, input logic p,
                                 input logic wbk, input logic [3:0] br,
                                 input logic [31:0] base, input logic [15:0] list);
        is_load   = ld;
        up        = u;
        pre       = p;
        writeback = wbk;
        base_reg  = br;
        base_addr = base;
        reg_list  = list;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    task automatic applyStimulus(input logic ld, input logic u, input logic p,
                                 input logic wbk, input logic [3:0] br,
                                 input logic [31:0] base, input logic [15:0] list,
                                 input int stall_beat, input int stall_n, input int poke_at);
        int c;
        int cnt;
        int exp_cycles;
        cnt        = $countones(list);
        exp_cycles = (cnt == 0) ? 2 : 2 + cnt + (wbk ? 1 : 0) + stall_n;
        build_expect(ld, u, p, wbk, br, base, list);
        beat_num   = 0;
        stall_at   = stall_beat;
        stall_left = stall_n;
        drive_request(ld, u, p, wbk, br, base, list);
        c = 1;
        checkOutput("busy_setup", 32'(busy), 32'd1);
        while (!done && c < 200) begin
            if (c == poke_at) begin
                start     = 1'b1;
                is_load   = !ld;
                reg_list  = 16'hFFFF;
                base_addr = 32'hDEAD_0000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        checkOutput("done_cycle", 32'(c), 32'(exp_cycles));
        checkOutput("done_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("done_pulse", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("beats_left", 32'(exp_beats.size()), 32'd0);
        checkOutput("writes_left", 32'(exp_writes.size()), 32'd0);
        exp_beats.delete();
        exp_writes.delete();
        stall_at = -1;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_r_addr_a"}, 32'(r_addr_a), 32'd0);
        checkOutput({tag, "_strobes"}, 32'({write_reg, write_pc, mem_we}), 32'd0);
        checkOutput({tag, "_w_data"}, w_data, 32'd0);
    endtask

    // Test sequence
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] STM IA with writeback");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0000_1000, 16'h000B, -1, 0, 0);
        $display("[TB] LDM DB including PC");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 32'h0000_2000, 16'h8003, -1, 0, 0);
        $display("[TB] LDM IA, base register in list");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0000_3000, 16'h0004, -1, 0, 0);
        $display("[TB] Empty list");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h0000_4000, 16'h0000, -1, 0, 0);
        $display("[TB] STM IA with stall and ignored start");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'h0000_5000, 16'h0136, 1, 3, 3);
        $display("[TB] STM DA wrapping below zero, base R15");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 32'h0000_0004, 16'h00F0, -1, 0, 0);
        $display("[TB] LDM IB with writeback");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 32'h0000_0100, 16'h4201, -1, 0, 0);

        $display("[TB] Reset mid-transfer");
        build_expect(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0000_7000, 16'h00FF);
        beat_num = 0;
        drive_request(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0000_7000, 16'h00FF);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("pre_reset_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_beats.delete();
        exp_writes.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 32'h0000_9000, 16'hFFFF, -1, 0, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
